// File: rtl/cpu_mem_pkg.sv
// Shared store-path definitions: access-size encodings, store FSM states and
// the size-to-byte-count helper.
package cpu_mem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BEAT1 = 2'b01,
      ST_BEAT2 = 2'b10
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      logic [3:0] n;
      case (size)
         SIZE_B:  n = 4'd1;
         SIZE_H:  n = 4'd2;
         SIZE_W:  n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/store_lane_calc.sv
// Combinational lane math for one store: byte enables and shifted data for the
// low beat and for the spill-over beat when the access crosses the word.
module store_lane_calc
   import cpu_mem_pkg::*;
#(
   parameter int  DATA_W           = 32,
   parameter int  SPLIT_MISALIGNED = 0,
   localparam int NB               = DATA_W / 8,
   localparam int OW               = $clog2(NB)
) (
   input  logic [1:0]        size,
   input  logic [OW-1:0]     offset,
   input  logic [DATA_W-1:0] data,
   output logic [NB-1:0]     be,
   output logic [DATA_W-1:0] wdata,
   output logic [NB-1:0]     hi_be,
   output logic [DATA_W-1:0] hi_wdata,
   output logic              crosses,
   output logic              misaligned
);

   logic [3:0]          nbytes_s;
   logic [3:0]          off_ext_s;
   logic [NB-1:0]       lane_mask_s;
   logic [DATA_W-1:0]   data_mask_s;
   logic [2*NB-1:0]     be_wide_s;
   logic [2*DATA_W-1:0] data_wide_s;
   logic                illegal_s;
   logic                unaligned_s;

   // Double-width shifts so the upper half directly yields the second beat.
   always_comb begin
      nbytes_s    = size_bytes(size);
      off_ext_s   = 4'(offset);
      lane_mask_s = '0;
      data_mask_s = '0;
      for (int i = 0; i < NB; i++) begin
         lane_mask_s[i] = (4'(i) < nbytes_s);
      end
      for (int i = 0; i < NB; i++) begin
         data_mask_s[8*i +: 8] = {8{lane_mask_s[i]}};
      end
      be_wide_s   = {{NB{1'b0}}, lane_mask_s} << offset;
      data_wide_s = {{DATA_W{1'b0}}, data & data_mask_s} << {offset, 3'b000};
      unaligned_s = ((off_ext_s & (nbytes_s - 4'd1)) != 4'd0);
      illegal_s   = (size == SIZE_D) && (NB < 8);
      be          = be_wide_s[NB-1:0];
      hi_be       = be_wide_s[2*NB-1:NB];
      wdata       = data_wide_s[DATA_W-1:0];
      hi_wdata    = data_wide_s[2*DATA_W-1:DATA_W];
      crosses     = |be_wide_s[2*NB-1:NB];
      if (illegal_s) begin
         misaligned = 1'b1;
      end else if (SPLIT_MISALIGNED == 0) begin
         misaligned = unaligned_s;
      end else begin
         misaligned = 1'b0;
      end
   end

endmodule

// File: rtl/store_lane_unit.sv
// Store byte-lane unit: turns accepted stores into registered valid/ready memory
// beats, splitting word-crossing stores or flagging them as address errors.
module store_lane_unit
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int SPLIT_MISALIGNED = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_size,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_data,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_last,
   output logic                misalign_exc,
   output logic [ADDR_W-1:0]   bad_addr
);

   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);

   logic [NB-1:0]     c_be_s;
   logic [NB-1:0]     c_hi_be_s;
   logic [DATA_W-1:0] c_wdata_s;
   logic [DATA_W-1:0] c_hi_wdata_s;
   logic              c_crosses_s;
   logic              c_misaligned_s;

   state_e            state_q, state_d;
   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_last_q, mem_last_d;
   logic [NB-1:0]     hi_be_q, hi_be_d;
   logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
   logic              misalign_exc_q, misalign_exc_d;
   logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

   logic beat_done_s;
   logic accept_s;

   store_lane_calc #(
      .DATA_W           (DATA_W),
      .SPLIT_MISALIGNED (SPLIT_MISALIGNED)
   ) u_calc (
      .size       (req_size),
      .offset     (req_addr[OW-1:0]),
      .data       (req_data),
      .be         (c_be_s),
      .wdata      (c_wdata_s),
      .hi_be      (c_hi_be_s),
      .hi_wdata   (c_hi_wdata_s),
      .crosses    (c_crosses_s),
      .misaligned (c_misaligned_s)
   );

   // Ready also opens while the final beat retires, so stores stream without a bubble.
   assign beat_done_s = mem_valid_q & mem_ready;
   assign req_ready   = (state_q == ST_IDLE) | (beat_done_s & mem_last_q);
   assign accept_s    = req_valid & req_ready & ~flush;

   assign mem_valid    = mem_valid_q;
   assign mem_addr     = mem_addr_q;
   assign mem_be       = mem_be_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_last     = mem_last_q;
   assign misalign_exc = misalign_exc_q;
   assign bad_addr     = bad_addr_q;

   // Next-state and next-output logic for the beat sequencer.
   always_comb begin
      state_d        = state_q;
      mem_valid_d    = mem_valid_q;
      mem_addr_d     = mem_addr_q;
      mem_be_d       = mem_be_q;
      mem_wdata_d    = mem_wdata_q;
      mem_last_d     = mem_last_q;
      hi_be_d        = hi_be_q;
      hi_wdata_d     = hi_wdata_q;
      misalign_exc_d = 1'b0;
      bad_addr_d     = bad_addr_q;
      if (flush) begin
         state_d     = ST_IDLE;
         mem_valid_d = 1'b0;
      end else if (accept_s) begin
         if (c_misaligned_s) begin
            misalign_exc_d = 1'b1;
            bad_addr_d     = req_addr;
            state_d        = ST_IDLE;
            mem_valid_d    = 1'b0;
         end else begin
            state_d     = ST_BEAT1;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            mem_be_d    = c_be_s;
            mem_wdata_d = c_wdata_s;
            mem_last_d  = ~c_crosses_s;
            hi_be_d     = c_hi_be_s;
            hi_wdata_d  = c_hi_wdata_s;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_valid_d = 1'b0;
            end
            ST_BEAT1: begin
               if (beat_done_s && mem_last_q) begin
                  state_d     = ST_IDLE;
                  mem_valid_d = 1'b0;
               end else if (beat_done_s) begin
                  state_d     = ST_BEAT2;
                  mem_addr_d  = mem_addr_q + ADDR_W'(NB);
                  mem_be_d    = hi_be_q;
                  mem_wdata_d = hi_wdata_q;
                  mem_last_d  = 1'b1;
               end else begin
                  state_d = ST_BEAT1;
               end
            end
            ST_BEAT2: begin
               if (beat_done_s) begin
                  state_d     = ST_IDLE;
                  mem_valid_d = 1'b0;
               end else begin
                  state_d = ST_BEAT2;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               mem_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         mem_valid_q    <= 1'b0;
         mem_addr_q     <= '0;
         mem_be_q       <= '0;
         mem_wdata_q    <= '0;
         mem_last_q     <= 1'b0;
         hi_be_q        <= '0;
         hi_wdata_q     <= '0;
         misalign_exc_q <= 1'b0;
         bad_addr_q     <= '0;
      end else begin
         state_q        <= state_d;
         mem_valid_q    <= mem_valid_d;
         mem_addr_q     <= mem_addr_d;
         mem_be_q       <= mem_be_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_last_q     <= mem_last_d;
         hi_be_q        <= hi_be_d;
         hi_wdata_q     <= hi_wdata_d;
         misalign_exc_q <= misalign_exc_d;
         bad_addr_q     <= bad_addr_d;
      end
   end

endmodule

// File: tb/tb_store_lane_unit.sv
// Directed bench: a 32-bit split-mode instance and a 64-bit exception-mode instance.
module tb_store_lane_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic flush;

   logic        a_req_valid, a_req_ready, a_mem_valid, a_mem_ready, a_mem_last, a_exc;
   logic [1:0]  a_req_size;
   logic [31:0] a_req_addr, a_req_data, a_mem_addr, a_mem_wdata, a_bad;
   logic [3:0]  a_mem_be;

   logic        b_req_valid, b_req_ready, b_mem_valid, b_mem_ready, b_mem_last, b_exc;
   logic [1:0]  b_req_size;
   logic [31:0] b_req_addr, b_mem_addr, b_bad;
   logic [63:0] b_req_data, b_mem_wdata;
   logic [7:0]  b_mem_be;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   store_lane_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_size(a_req_size),
      .req_addr(a_req_addr), .req_data(a_req_data),
      .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
      .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_last(a_mem_last),
      .misalign_exc(a_exc), .bad_addr(a_bad)
   );

   store_lane_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_MISALIGNED(0)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_size(b_req_size),
      .req_addr(b_req_addr), .req_data(b_req_data),
      .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
      .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_last(b_mem_last),
      .misalign_exc(b_exc), .bad_addr(b_bad)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_req(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dt);
      a_req_valid = 1'b1;
      a_req_size  = sz;
      a_req_addr  = ad;
      a_req_data  = dt;
   endtask

   task automatic b_req(input logic [1:0] sz, input logic [31:0] ad, input logic [63:0] dt);
      b_req_valid = 1'b1;
      b_req_size  = sz;
      b_req_addr  = ad;
      b_req_data  = dt;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      a_req_valid = 1'b0; a_req_size = 2'b00; a_req_addr = 32'h0; a_req_data = 32'h0; a_mem_ready = 1'b0;
      b_req_valid = 1'b0; b_req_size = 2'b00; b_req_addr = 32'h0; b_req_data = 64'h0; b_mem_ready = 1'b0;
      repeat (2) tick();

      chk("rst_a_valid", 64'(a_mem_valid), 64'h0);
      chk("rst_a_be",    64'(a_mem_be),    64'h0);
      chk("rst_a_wdata", 64'(a_mem_wdata), 64'h0);
      chk("rst_a_addr",  64'(a_mem_addr),  64'h0);
      chk("rst_a_last",  64'(a_mem_last),  64'h0);
      chk("rst_a_exc",   64'(a_exc),       64'h0);
      chk("rst_a_bad",   64'(a_bad),       64'h0);
      chk("rst_b_valid", 64'(b_mem_valid), 64'h0);
      chk("rst_b_wdata", b_mem_wdata,      64'h0);
      rst_n = 1'b1;
      tick();

      // sb 0x1002
      a_mem_ready = 1'b1;
      a_req(2'b00, 32'h0000_1002, 32'h0000_00AB);
      #1 chk("sb_ready_idle", 64'(a_req_ready), 64'h1);
      tick();
      chk("sb_valid", 64'(a_mem_valid), 64'h1);
      chk("sb_addr",  64'(a_mem_addr),  64'h1000);
      chk("sb_be",    64'(a_mem_be),    64'h4);
      chk("sb_wdata", 64'(a_mem_wdata), 64'h00AB_0000);
      chk("sb_last",  64'(a_mem_last),  64'h1);

      // back-to-back split sw 0x1003
      a_req(2'b10, 32'h0000_1003, 32'h1122_3344);
      #1 chk("b2b_ready", 64'(a_req_ready), 64'h1);
      tick();
      a_req_valid = 1'b0;
      chk("sw1_valid", 64'(a_mem_valid), 64'h1);
      chk("sw1_addr",  64'(a_mem_addr),  64'h1000);
      chk("sw1_be",    64'(a_mem_be),    64'h8);
      chk("sw1_wdata", 64'(a_mem_wdata), 64'h4400_0000);
      chk("sw1_last",  64'(a_mem_last),  64'h0);
      #1 chk("sw1_ready", 64'(a_req_ready), 64'h0);
      tick();
      chk("sw2_addr",  64'(a_mem_addr),  64'h1004);
      chk("sw2_be",    64'(a_mem_be),    64'h7);
      chk("sw2_wdata", 64'(a_mem_wdata), 64'h0011_2233);
      chk("sw2_last",  64'(a_mem_last),  64'h1);
      tick();
      chk("sw_idle", 64'(a_mem_valid), 64'h0);

      // dword on 32-bit always faults, even in split mode
      a_req(2'b11, 32'h0000_4000, 32'h0);
      tick();
      a_req_valid = 1'b0;
      chk("sd32_exc",   64'(a_exc),       64'h1);
      chk("sd32_bad",   64'(a_bad),       64'h4000);
      chk("sd32_valid", 64'(a_mem_valid), 64'h0);
      tick();
      chk("sd32_exc_pulse", 64'(a_exc), 64'h0);

      // second beat wraps past the top of the address space
      a_req(2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD);
      tick();
      a_req_valid = 1'b0;
      chk("wrap1_addr",  64'(a_mem_addr),  64'hFFFF_FFFC);
      chk("wrap1_be",    64'(a_mem_be),    64'hC);
      chk("wrap1_wdata", 64'(a_mem_wdata), 64'hCCDD_0000);
      tick();
      chk("wrap2_addr",  64'(a_mem_addr),  64'h0);
      chk("wrap2_be",    64'(a_mem_be),    64'h3);
      chk("wrap2_wdata", 64'(a_mem_wdata), 64'h0000_AABB);
      tick();

      // sh at offset 1 fits in one beat; upper data bits are masked off
      a_req(2'b01, 32'h0000_6001, 32'hFFFF_1234);
      tick();
      a_req_valid = 1'b0;
      chk("sh1_be",    64'(a_mem_be),    64'h6);
      chk("sh1_wdata", 64'(a_mem_wdata), 64'h0012_3400);
      chk("sh1_last",  64'(a_mem_last),  64'h1);
      tick();

      // backpressure with a queued request
      a_mem_ready = 1'b0;
      a_req(2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
      tick();
      a_req(2'b00, 32'h0000_3005, 32'h7777_775A);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 64'(a_mem_valid), 64'h1);
         chk("bp_addr",  64'(a_mem_addr),  64'h3000);
         chk("bp_be",    64'(a_mem_be),    64'hF);
         chk("bp_wdata", 64'(a_mem_wdata), 64'hDEAD_BEEF);
         chk("bp_ready", 64'(a_req_ready), 64'h0);
         tick();
      end
      a_mem_ready = 1'b1;
      #1 chk("bp_ready_open", 64'(a_req_ready), 64'h1);
      tick();
      a_req_valid = 1'b0;
      chk("q_valid", 64'(a_mem_valid), 64'h1);
      chk("q_addr",  64'(a_mem_addr),  64'h3004);
      chk("q_be",    64'(a_mem_be),    64'h2);
      chk("q_wdata", 64'(a_mem_wdata), 64'h0000_5A00);
      tick();
      chk("q_idle", 64'(a_mem_valid), 64'h0);

      // flush after BEAT1 is accepted drops BEAT2
      a_req(2'b01, 32'h0000_5003, 32'h0000_BBCC);
      tick();
      a_req_valid = 1'b0;
      chk("fl_b1_be",    64'(a_mem_be),    64'h8);
      chk("fl_b1_wdata", 64'(a_mem_wdata), 64'hCC00_0000);
      chk("fl_b1_last",  64'(a_mem_last),  64'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", 64'(a_mem_valid), 64'h0);
      chk("fl_ready", 64'(a_req_ready), 64'h1);

      // request in the flush cycle is not accepted
      a_req(2'b00, 32'h0000_5000, 32'h0000_0011);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      a_req_valid = 1'b0;
      chk("fl_req_dropped", 64'(a_mem_valid), 64'h0);
      tick();

      // 64-bit: misaligned sh faults
      b_mem_ready = 1'b1;
      b_req(2'b01, 32'h0000_2001, 64'h5555);
      tick();
      b_req_valid = 1'b0;
      chk("b_mis_exc",   64'(b_exc),       64'h1);
      chk("b_mis_bad",   64'(b_bad),       64'h2001);
      chk("b_mis_valid", 64'(b_mem_valid), 64'h0);
      chk("b_mis_ready", 64'(b_req_ready), 64'h1);
      tick();
      chk("b_mis_pulse", 64'(b_exc), 64'h0);

      // 64-bit: sd then back-to-back sw in the upper half
      b_req(2'b11, 32'h0000_0008, 64'h0102_0304_0506_0708);
      tick();
      b_req(2'b10, 32'h0000_000C, 64'hCAFE_F00D_1234_5678);
      chk("b_sd_be",    64'(b_mem_be),   64'hFF);
      chk("b_sd_addr",  64'(b_mem_addr), 64'h8);
      chk("b_sd_wdata", b_mem_wdata,     64'h0102_0304_0506_0708);
      chk("b_sd_last",  64'(b_mem_last), 64'h1);
      #1 chk("b_b2b_ready", 64'(b_req_ready), 64'h1);
      tick();
      b_req_valid = 1'b0;
      chk("b_sw_be",    64'(b_mem_be),   64'hF0);
      chk("b_sw_addr",  64'(b_mem_addr), 64'h8);
      chk("b_sw_wdata", b_mem_wdata,     64'h1234_5678_0000_0000);
      tick();
      chk("b_idle", 64'(b_mem_valid), 64'h0);

      // asynchronous reset in the middle of a split store
      a_mem_ready = 1'b0;
      a_req(2'b01, 32'h0000_5003, 32'h0000_BBCC);
      tick();
      a_req_valid = 1'b0;
      chk("mr_valid_pre", 64'(a_mem_valid), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", 64'(a_mem_valid), 64'h0);
      chk("mr_be",    64'(a_mem_be),    64'h0);
      chk("mr_wdata", 64'(a_mem_wdata), 64'h0);
      chk("mr_addr",  64'(a_mem_addr),  64'h0);
      chk("mr_bad",   64'(a_bad),       64'h0);
      chk("mr_b_bad", 64'(b_bad),       64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mr_idle_valid", 64'(a_mem_valid), 64'h0);
      chk("mr_idle_ready", 64'(a_req_ready), 64'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
